// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store initiator between the MEM stage and data_memory
// Checks funct3, alignment and range, drives single-cycle strobes and extends load data.
module lsu_mem_initiator #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_is_store,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_cause,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data_input,
  output logic [2:0]  load_format,
  output logic [1:0]  store_format,
  input  logic [63:0] mem_data_output
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [64:0] LP_LIMIT = 65'(MEM_BYTES);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_load_format;
  logic [1:0]  r_store_format;
  logic        r_write_en;
  logic        r_read_en;
  logic        r_resp_valid;
  logic [63:0] r_rdata;
  logic        r_resp_is_store;
  logic        r_fault;
  logic [1:0]  r_cause;

  logic        w_accept;
  logic [3:0]  w_size;
  logic [2:0]  w_mask;
  logic [64:0] w_end;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic [2:0]  w_load_format;
  logic [63:0] w_ext;

  assign w_accept       = req_valid & r_req_ready;
  assign w_size         = 4'd1 << req_funct3[1:0];
  assign w_mask         = w_size[2:0] - 3'd1;
  // 65-bit sum so addresses near 2^64 cannot wrap back into range
  assign w_end          = {1'b0, req_addr} + {61'd0, w_size} - 65'd1;
  assign w_illegal      = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
  assign w_misaligned   = (req_addr[2:0] & w_mask) != 3'd0;
  assign w_out_of_range = w_end >= LP_LIMIT;
  assign w_load_format  = (req_funct3[1:0] == 2'b11) ? 3'b101 : {1'b0, req_funct3[1:0]};

  always_comb begin
    w_ext = '0;
    case (r_funct3)
      3'b000:  w_ext = {{56{mem_data_output[7]}},  mem_data_output[7:0]};
      3'b001:  w_ext = {{48{mem_data_output[15]}}, mem_data_output[15:0]};
      3'b010:  w_ext = {{32{mem_data_output[31]}}, mem_data_output[31:0]};
      3'b011:  w_ext = mem_data_output;
      3'b100:  w_ext = {56'd0, mem_data_output[7:0]};
      3'b101:  w_ext = {48'd0, mem_data_output[15:0]};
      3'b110:  w_ext = {32'd0, mem_data_output[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b0;
      r_is_store      <= 1'b0;
      r_funct3        <= 3'd0;
      r_addr          <= 64'd0;
      r_wdata         <= 64'd0;
      r_load_format   <= 3'd0;
      r_store_format  <= 2'd0;
      r_write_en      <= 1'b0;
      r_read_en       <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_rdata         <= 64'd0;
      r_resp_is_store <= 1'b0;
      r_fault         <= 1'b0;
      r_cause         <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready     <= 1'b0;
            r_is_store      <= req_is_store;
            r_funct3        <= req_funct3;
            r_addr          <= req_addr;
            r_wdata         <= req_wdata;
            r_load_format   <= w_load_format;
            r_store_format  <= req_funct3[1:0];
            r_resp_is_store <= req_is_store;
            r_rdata         <= 64'd0;
            r_fault         <= 1'b1;
            if (w_illegal) begin
              r_cause      <= 2'b11;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_misaligned) begin
              r_cause      <= 2'b01;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (w_out_of_range) begin
              r_cause      <= 2'b10;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_fault    <= 1'b0;
              r_cause    <= 2'b00;
              r_write_en <= req_is_store;
              r_read_en  <= ~req_is_store;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_write_en   <= 1'b0;
          r_read_en    <= 1'b0;
          r_rdata      <= r_is_store ? 64'd0 : w_ext;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_rdata;
  assign resp_is_store    = r_resp_is_store;
  assign resp_fault       = r_fault;
  assign resp_fault_cause = r_cause;
  assign mem_write_en     = r_write_en;
  assign mem_read_en      = r_read_en;
  assign mem_addr         = r_addr;
  assign mem_data_input   = r_wdata;
  assign load_format      = r_load_format;
  assign store_format     = r_store_format;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed self-checking bench for lsu_mem_initiator
// Includes a byte-addressed memory that reads combinationally and writes on the clock edge.
module tb_lsu_mem_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_is_store;
  logic        resp_fault;
  logic [1:0]  resp_fault_cause;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_input;
  logic [2:0]  load_format;
  logic [1:0]  store_format;
  logic [63:0] mem_data_output;

  int vectors = 0;
  int miscompares = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic [7:0] mem [0:4095];

  lsu_mem_initiator #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_is_store(resp_is_store), .resp_fault(resp_fault), .resp_fault_cause(resp_fault_cause),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_data_input(mem_data_input), .load_format(load_format), .store_format(store_format),
    .mem_data_output(mem_data_output)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_data_output = 64'd0;
    for (int i = 0; i < 8; i++)
      mem_data_output[8*i +: 8] = mem[12'(mem_addr[11:0] + 12'(i))];
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < (1 << store_format); i++)
        mem[12'(mem_addr[11:0] + 12'(i))] <= mem_data_input[8*i +: 8];
      wr_pulses++;
    end
    if (mem_read_en) rd_pulses++;
  end

  always @(negedge clk) begin
    if (mem_write_en && mem_read_en) begin
      miscompares++;
      $error("FAIL both_strobes: observed 11 expected not both set");
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0] t_rd;
  logic        t_flt;
  logic [1:0]  t_cause;
  int          t_lat;
  logic [2:0]  t_lf;
  logic [1:0]  t_sf;
  int          t_wr;
  int          t_rdp;

  task automatic xfer(input logic st, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, input int hold);
    int g;
    int wr0;
    int rd0;
    logic [63:0] snap;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_before", {63'd0, req_ready}, 64'd1);
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t_lat = 1;
    t_lf = load_format;
    t_sf = store_format;
    while (!resp_valid && t_lat < 10) begin
      @(posedge clk); #1;
      t_lat++;
    end
    t_rd = resp_rdata; t_flt = resp_fault; t_cause = resp_fault_cause;
    snap = resp_rdata;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, snap);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_strobes", {62'd0, mem_write_en, mem_read_en}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    t_wr = wr_pulses - wr0;
    t_rdp = rd_pulses - rd0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_outputs", {59'd0, resp_valid, resp_is_store, resp_fault, resp_fault_cause}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_strobes", {62'd0, mem_write_en, mem_read_en}, 64'd0);
    chk("rst_mem_bus", mem_addr | mem_data_input, 64'd0);
    chk("rst_formats", {59'd0, load_format, store_format}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

    xfer(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 0);
    chk("sd_fmt", {62'd0, t_sf}, 64'd3);
    chk("sd_wr_pulses", 64'(t_wr), 64'd1);
    chk("sd_lat", 64'(t_lat), 64'd2);
    chk("sd_resp", {t_rd[60:0], t_flt, t_cause}, 64'd0);

    xfer(1'b0, 3'b011, 64'h10, 64'd0, 0);
    chk("ld_data", t_rd, 64'h1122334455667788);
    chk("ld_lat", 64'(t_lat), 64'd2);
    chk("ld_fmt", {61'd0, t_lf}, 64'b101);
    chk("ld_pulses", {32'(t_wr), 32'(t_rdp)}, {32'd0, 32'd1});

    xfer(1'b1, 3'b000, 64'h20, 64'h80, 0);
    xfer(1'b0, 3'b000, 64'h20, 64'd0, 0);
    chk("lb_data", t_rd, 64'hFFFFFFFFFFFFFF80);
    chk("lb_fmt", {61'd0, t_lf}, 64'd0);
    xfer(1'b0, 3'b100, 64'h20, 64'd0, 0);
    chk("lbu_data", t_rd, 64'h80);
    chk("lbu_fmt", {61'd0, t_lf}, 64'd0);

    xfer(1'b1, 3'b010, 64'h40, 64'hFFFF_0000_8000ABCD, 0);
    chk("sw_fmt", {62'd0, t_sf}, 64'd2);
    xfer(1'b0, 3'b010, 64'h40, 64'd0, 0);
    chk("lw_data", t_rd, 64'hFFFFFFFF8000ABCD);
    chk("lw_fmt", {61'd0, t_lf}, 64'b010);
    xfer(1'b0, 3'b110, 64'h40, 64'd0, 0);
    chk("lwu_data", t_rd, 64'h000000008000ABCD);
    chk("lwu_fmt", {61'd0, t_lf}, 64'b010);
    xfer(1'b0, 3'b101, 64'h40, 64'd0, 0);
    chk("lhu_data", t_rd, 64'hABCD);
    chk("lhu_fmt", {61'd0, t_lf}, 64'b001);
    xfer(1'b0, 3'b001, 64'h42, 64'd0, 0);
    chk("lh_data", t_rd, 64'hFFFFFFFFFFFF8000);

    xfer(1'b0, 3'b001, 64'h101, 64'd0, 0);
    chk("lh_mis_fault", {61'd0, t_flt, t_cause}, 64'b101);
    chk("lh_mis_lat", 64'(t_lat), 64'd1);
    chk("lh_mis_strobes", {32'(t_wr), 32'(t_rdp)}, 64'd0);
    xfer(1'b1, 3'b010, 64'd4096, 64'd0, 0);
    chk("sw_oor_fault", {61'd0, t_flt, t_cause}, 64'b110);
    chk("sw_oor_strobes", 64'(t_wr), 64'd0);
    xfer(1'b1, 3'b010, 64'd4094, 64'd0, 0);
    chk("sw_mis_over_oor", {61'd0, t_flt, t_cause}, 64'b101);
    xfer(1'b1, 3'b100, 64'h3, 64'd0, 0);
    chk("st_illegal_fault", {61'd0, t_flt, t_cause}, 64'b111);
    chk("st_illegal_rdata", t_rd, 64'd0);
    xfer(1'b0, 3'b111, 64'h0, 64'd0, 0);
    chk("ld_illegal_fault", {61'd0, t_flt, t_cause}, 64'b111);
    xfer(1'b0, 3'b010, 64'd4092, 64'd0, 0);
    chk("lw_top_clean", {61'd0, t_flt, t_cause}, 64'd0);
    xfer(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0);
    chk("ld_wrap_oor", {61'd0, t_flt, t_cause}, 64'b110);

    xfer(1'b0, 3'b011, 64'h10, 64'd0, 3);
    chk("bp_data", t_rd, 64'h1122334455667788);
    chk("bp_rd_pulses", 64'(t_rdp), 64'd1);

    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h10; req_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_we_on", {63'd0, mem_write_en}, 64'd1);
    t_wr = wr_pulses;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_off", {63'd0, mem_write_en}, 64'd0);
    chk("rst_mid_outs", {61'd0, resp_valid, req_ready, mem_read_en}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_no_write", 64'(wr_pulses - t_wr), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    xfer(1'b0, 3'b011, 64'h10, 64'd0, 0);
    chk("rst_mid_ld", t_rd, 64'h1122334455667788);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
